dbus_scratchpad_slave: RTL and testbench

// - Responder (slave modport) for cpu_dbus_if, backed by an on-chip 64-bit-wide scratchpad SRAM.
// - Serves the cached (read/write) and uncached (uncached_read/uncached_write) channels with

---
 rtl/dbus_scratch_pkg.sv | 34 +++
 rtl/cpu_dbus_if.sv | 30 +++
 rtl/dbus_resp_channel.sv | 90 +++++++++
 rtl/dbus_scratchpad_slave.sv | 115 +++++++++++
 tb/tb_dbus_scratchpad_slave.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/dbus_scratch_pkg.sv
// Shared types and helpers for the scratchpad data-bus responder.
package dbus_scratch_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned BE_W      = DATA_W / 8;
    // Word index carried in a request: address[31:3]; the top slices what it needs.
    localparam int unsigned IDX_MAX_W = 29;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } chan_state_e;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        logic [DATA_W-1:0]    wrdata;
        logic [BE_W-1:0]      be;
        logic                 is_write;
        logic                 is_read;
    } chan_req_t;

    // Replace the byte lanes of old_w selected by be with the matching lanes of new_w.
    function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] merged;
        for (int i = 0; i < BE_W; i++) begin
            merged[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/cpu_dbus_if.sv
// CPU data-bus interface: cached and uncached channels sharing one address/data path.
interface cpu_dbus_if;

    logic        read;
    logic        write;
    logic        uncached_read;
    logic        uncached_write;
    logic [31:0] address;
    logic [7:0]  byteenable;
    logic [63:0] wrdata;
    logic        icache_inv;
    logic        dcache_inv;
    logic        stall;
    logic [63:0] rddata;
    logic        uncached_stall;
    logic [63:0] uncached_rddata;

    modport master (
        output read, write, uncached_read, uncached_write, address, byteenable, wrdata,
               icache_inv, dcache_inv,
        input  stall, rddata, uncached_stall, uncached_rddata
    );

    modport slave (
        input  read, write, uncached_read, uncached_write, address, byteenable, wrdata,
               icache_inv, dcache_inv,
        output stall, rddata, uncached_stall, uncached_rddata
    );

endinterface

// File: rtl/dbus_resp_channel.sv
// One responder channel: IDLE/BUSY/DONE sequencing, latency counter, request latch,
// stall generation and a commit strobe for the shared SRAM port.
module dbus_resp_channel
    import dbus_scratch_pkg::*;
#(
    parameter int unsigned LAT       = 2,  // stall cycles for a read/write
    parameter int unsigned LAT_NOACC = 1   // stall cycles for a request with no SRAM access
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      req,
    input  chan_req_t req_info,
    input  logic      grant,
    output logic      stall,
    output logic      commit,
    output chan_req_t cur_req
);

    localparam int unsigned MAX_LAT = (LAT > LAT_NOACC) ? LAT : LAT_NOACC;
    localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT - 1) : 1;

    // The request cycle is the first stall cycle and the commit cycle is the last, so BUSY
    // counts down LAT-2 extra cycles before the commit cycle (none when LAT <= 2).
    localparam logic [CNT_W-1:0] LOAD_ACC   = CNT_W'((LAT > 1) ? LAT - 2 : 0);
    localparam logic [CNT_W-1:0] LOAD_NOACC = CNT_W'((LAT_NOACC > 1) ? LAT_NOACC - 2 : 0);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    chan_req_t        req_q, req_d;
    logic             is_access;
    logic             single_cycle;
    logic             last_cycle;

    assign is_access    = req_info.is_read | req_info.is_write;
    assign single_cycle = is_access ? (LAT == 1) : (LAT_NOACC == 1);
    // A one-cycle access commits straight out of IDLE using the live request.
    assign last_cycle   = (state_q == IDLE) ? single_cycle : ((state_q == BUSY) && (cnt_q == '0));
    assign cur_req      = (state_q == IDLE) ? req_info : req_q;
    assign commit       = req & last_cycle & grant;
    assign stall        = req & (state_q != DONE);

    // Next-state, countdown and request-latch logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    req_d   = req_info;
                    cnt_d   = is_access ? LOAD_ACC : LOAD_NOACC;
                    state_d = commit ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (!req) begin
                    // Master abandoned the request: drop it without committing.
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (grant) begin
                    state_d = DONE;
                end
                // cnt==0 without grant: hold in BUSY with the counter saturated.
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample together.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

endmodule

// File: rtl/dbus_scratchpad_slave.sv
// Scratchpad SRAM responder for cpu_dbus_if: two channels sharing one SRAM port,
// cached channel with fixed priority, registered read data per channel.
module dbus_scratchpad_slave
    import dbus_scratch_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned CACHED_LAT   = 2,
    parameter int unsigned UNCACHED_LAT = 4,
    parameter int unsigned INV_LAT      = 1
) (
    input logic       clk,
    input logic       rst_n,
    cpu_dbus_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    chan_req_t         c_info, u_info, c_cur, u_cur;
    logic              c_req, u_req;
    logic              c_commit, u_commit, u_grant;
    logic              c_stall, u_stall;
    logic [IDX_W-1:0]  c_idx, u_idx, wr_idx;
    logic [DATA_W-1:0] c_word, u_word, wr_word;
    logic              wr_en;
    logic [DATA_W-1:0] rddata_q, rddata_d;
    logic [DATA_W-1:0] u_rddata_q, u_rddata_d;
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic              unused_addr_bits;

    assign c_req  = bus.read | bus.write | bus.icache_inv | bus.dcache_inv;
    assign u_req  = bus.uncached_read | bus.uncached_write;

    assign c_info = '{idx: bus.address[31:3], wrdata: bus.wrdata, be: bus.byteenable,
                      is_write: bus.write, is_read: bus.read};
    assign u_info = '{idx: bus.address[31:3], wrdata: bus.wrdata, be: bus.byteenable,
                      is_write: bus.uncached_write, is_read: bus.uncached_read};

    // The cached channel owns the SRAM port whenever it commits a real access.
    assign u_grant = ~(c_commit & (c_cur.is_read | c_cur.is_write));

    dbus_resp_channel #(.LAT(CACHED_LAT), .LAT_NOACC(INV_LAT)) u_cached_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (c_req),
        .req_info (c_info),
        .grant    (1'b1),
        .stall    (c_stall),
        .commit   (c_commit),
        .cur_req  (c_cur)
    );

    dbus_resp_channel #(.LAT(UNCACHED_LAT), .LAT_NOACC(UNCACHED_LAT)) u_uncached_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (u_req),
        .req_info (u_info),
        .grant    (u_grant),
        .stall    (u_stall),
        .commit   (u_commit),
        .cur_req  (u_cur)
    );

    // Addresses wrap modulo DEPTH_WORDS; sub-word and upper bits are ignored.
    assign c_idx  = c_cur.idx[IDX_W-1:0];
    assign u_idx  = u_cur.idx[IDX_W-1:0];
    assign c_word = mem_q[c_idx];
    assign u_word = mem_q[u_idx];

    assign unused_addr_bits = ^{bus.address[2:0], c_cur.idx[IDX_MAX_W-1:IDX_W],
                                u_cur.idx[IDX_MAX_W-1:IDX_W]};

    // Commit path: capture pre-write read data and steer the single SRAM write port.
    always_comb begin
        wr_en      = 1'b0;
        wr_idx     = c_idx;
        wr_word    = be_merge(c_word, c_cur.wrdata, c_cur.be);
        rddata_d   = rddata_q;
        u_rddata_d = u_rddata_q;
        if (c_commit) begin
            if (c_cur.is_read) rddata_d = c_word;
            wr_en = c_cur.is_write;
        end
        if (u_commit) begin
            if (u_cur.is_read) u_rddata_d = u_word;
            if (u_cur.is_write) begin
                wr_en   = 1'b1;
                wr_idx  = u_idx;
                wr_word = be_merge(u_word, u_cur.wrdata, u_cur.be);
            end
        end
    end

    // SRAM write port.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately left out of reset so it maps onto a real SRAM macro.
        if (wr_en) mem_q[wr_idx] <= wr_word;
    end

    // Read-data registers, one per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rddata_q   <= '0;
            u_rddata_q <= '0;
        end else begin
            rddata_q   <= rddata_d;
            u_rddata_q <= u_rddata_d;
        end
    end

    assign bus.stall           = c_stall;
    assign bus.rddata          = rddata_q;
    assign bus.uncached_stall  = u_stall;
    assign bus.uncached_rddata = u_rddata_q;

endmodule

// File: tb/tb_dbus_scratchpad_slave.sv
// Directed self-checking bench for dbus_scratchpad_slave (CACHED_LAT=2, UNCACHED_LAT=4, INV_LAT=1).
module tb_dbus_scratchpad_slave;

    localparam int MAX_WAIT = 20;

    localparam logic [63:0] W5_INIT  = 64'h1122_3344_5566_7788;
    localparam logic [63:0] W5_MERGE = 64'h1122_3344_BBBB_BBBB;
    localparam logic [63:0] W1_VAL   = 64'h0101_0202_0303_0404;
    localparam logic [63:0] W2_VAL   = 64'hA5A5_5A5A_C3C3_3C3C;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    cpu_dbus_if bus_if ();

    dbus_scratchpad_slave #(
        .DEPTH_WORDS  (1024),
        .CACHED_LAT   (2),
        .UNCACHED_LAT (4),
        .INV_LAT      (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clear_bus();
        bus_if.read           = 1'b0;
        bus_if.write          = 1'b0;
        bus_if.uncached_read  = 1'b0;
        bus_if.uncached_write = 1'b0;
        bus_if.icache_inv     = 1'b0;
        bus_if.dcache_inv     = 1'b0;
        bus_if.address        = '0;
        bus_if.byteenable     = '0;
        bus_if.wrdata         = '0;
    endtask

    // One transaction on either channel; holds the request until stall drops (bounded).
    task automatic xact(input logic uc, input logic rd, input logic wr, input logic inv,
                        input logic [31:0] addr, input logic [7:0] be, input logic [63:0] data,
                        output int n_stall, output logic [63:0] rdata);
        @(posedge clk); #1;
        if (uc) begin
            bus_if.uncached_read  = rd;
            bus_if.uncached_write = wr;
        end else begin
            bus_if.read       = rd;
            bus_if.write      = wr;
            bus_if.icache_inv = inv;
        end
        bus_if.address    = addr;
        bus_if.byteenable = be;
        bus_if.wrdata     = data;
        n_stall = 0;
        rdata   = 'x;
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk);
            if (!(uc ? bus_if.uncached_stall : bus_if.stall)) begin
                rdata = uc ? bus_if.uncached_rddata : bus_if.rddata;
                break;
            end
            n_stall++;
        end
        @(posedge clk); #1;
        clear_bus();
    endtask

    initial begin : stimulus
        int          ns;
        logic [63:0] rd;
        logic [6:0]  c_pat, u_pat;
        logic [8:0]  b2b_pat;
        logic [63:0] c_at4, u_at5, b2b_data;

        // Reset state.
        rst_n = 1'b0;
        clear_bus();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall",    {63'd0, bus_if.stall},          64'd0);
        check("rst_ustall",   {63'd0, bus_if.uncached_stall}, 64'd0);
        check("rst_rddata",   bus_if.rddata,                  64'd0);
        check("rst_urddata",  bus_if.uncached_rddata,         64'd0);
        rst_n = 1'b1;

        // Full write of mem[5], then cached read: 2 stall cycles, data on the 3rd.
        xact(1'b0, 1'b0, 1'b1, 1'b0, 32'h28, 8'hFF, W5_INIT, ns, rd);
        check("wr5_stalls", 64'(ns), 64'd2);
        xact(1'b0, 1'b1, 1'b0, 1'b0, 32'h28, 8'h00, '0, ns, rd);
        check("rd5_stalls", 64'(ns), 64'd2);
        check("rd5_data",   rd,      W5_INIT);

        // Byte-lane write, low four lanes only.
        xact(1'b0, 1'b0, 1'b1, 1'b0, 32'h28, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, ns, rd);
        xact(1'b0, 1'b1, 1'b0, 1'b0, 32'h28, 8'h00, '0, ns, rd);
        check("be_merge", rd, W5_MERGE);

        // Aliasing: index wraps modulo 1024, upper address bits ignored.
        xact(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2028, 8'h00, '0, ns, rd);
        check("alias_wrap", rd, W5_MERGE);
        xact(1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0028, 8'h00, '0, ns, rd);
        check("alias_hi", rd, W5_MERGE);

        // Read+write in one request: old word returned, new word committed.
        xact(1'b0, 1'b0, 1'b1, 1'b0, 32'h38, 8'hFF, 64'hDEAD, ns, rd);
        xact(1'b0, 1'b1, 1'b1, 1'b0, 32'h38, 8'hFF, 64'h0, ns, rd);
        check("rw_old", rd, 64'hDEAD);
        xact(1'b0, 1'b1, 1'b0, 1'b0, 32'h38, 8'h00, '0, ns, rd);
        check("rw_new", rd, 64'h0);

        // Preload mem[1] (cached) and mem[2] (uncached, 4 stall cycles).
        xact(1'b0, 1'b0, 1'b1, 1'b0, 32'h08, 8'hFF, W1_VAL, ns, rd);
        xact(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 8'hFF, W2_VAL, ns, rd);
        check("uwr_stalls", 64'(ns), 64'd4);

        // Contention: uncached read of mem[2] from cycle 0, cached read of mem[1] from
        // cycle 2. Both want the port at the end of cycle 3; cached wins, uncached slips
        // one cycle (stall cycles 0..4, done in 5).
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(posedge clk); #1;
            bus_if.uncached_read = (cyc <= 5);
            bus_if.read          = (cyc >= 2) && (cyc <= 4);
            bus_if.address       = (cyc < 2) ? 32'h10 : 32'h08;
            @(negedge clk);
            c_pat[cyc] = bus_if.stall;
            u_pat[cyc] = bus_if.uncached_stall;
            if (cyc == 4) c_at4 = bus_if.rddata;
            if (cyc == 5) u_at5 = bus_if.uncached_rddata;
        end
        clear_bus();
        check("arb_c_stall", {57'd0, c_pat}, {57'd0, 7'b000_1100});
        check("arb_u_stall", {57'd0, u_pat}, {57'd0, 7'b001_1111});
        check("arb_c_data",  c_at4, W1_VAL);
        check("arb_u_data",  u_at5, W2_VAL);

        // Uncached request dropped while BUSY: no commit, data held, channel back to IDLE.
        @(posedge clk); #1;
        bus_if.uncached_read = 1'b1;
        bus_if.address       = 32'h28;
        @(posedge clk); #1;
        bus_if.uncached_read = 1'b0;
        @(posedge clk); #1;
        check("drop_hold", bus_if.uncached_rddata, W2_VAL);
        xact(1'b1, 1'b1, 1'b0, 1'b0, 32'h28, 8'h00, '0, ns, rd);
        check("drop_after_stalls", 64'(ns), 64'd4);
        check("drop_after_data",   rd,      W5_MERGE);

        // Back-to-back: read held for three transactions.
        for (int cyc = 0; cyc < 9; cyc++) begin
            @(posedge clk); #1;
            bus_if.read    = 1'b1;
            bus_if.address = 32'h28;
            @(negedge clk);
            b2b_pat[cyc] = bus_if.stall;
            if (cyc == 8) b2b_data = bus_if.rddata;
        end
        @(posedge clk); #1;
        clear_bus();
        check("b2b_stall", {55'd0, b2b_pat}, {55'd0, 9'b011_011_011});
        check("b2b_data",  b2b_data, W5_MERGE);

        // Invalidate only: one stall cycle, read data untouched.
        xact(1'b0, 1'b0, 1'b0, 1'b1, 32'h08, 8'h00, '0, ns, rd);
        check("inv_stalls", 64'(ns), 64'd1);
        check("inv_rddata", rd, W5_MERGE);

        // Reset in the middle of a cached write to mem[5].
        @(posedge clk); #1;
        bus_if.write      = 1'b1;
        bus_if.address    = 32'h28;
        bus_if.byteenable = 8'hFF;
        bus_if.wrdata     = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_stall_req", {63'd0, bus_if.stall}, 64'd1);
        check("rst_mid_rddata",    bus_if.rddata,          64'd0);
        check("rst_mid_urddata",   bus_if.uncached_rddata, 64'd0);
        #1;
        bus_if.write = 1'b0;
        #1;
        check("rst_mid_stall_noreq", {63'd0, bus_if.stall}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_bus();
        xact(1'b0, 1'b1, 1'b0, 1'b0, 32'h28, 8'h00, '0, ns, rd);
        check("rst_mid_word", rd, W5_MERGE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
